// File: rtl/hazard_if.sv
// Pipeline-hazard bus: ID/EX/MEM/WB register info in, per-stage stall/flush, forwarding and perf counters out.
interface hazard_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_pcsrc;
  logic [4:0]       mem_rd;
  logic [4:0]       wb_rd;
  logic             mem_regwrite;
  logic             wb_regwrite;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memtoreg, ex_pcsrc,
    output mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    output imem_ready, dmem_req, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  forward_a, forward_b,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memtoreg, ex_pcsrc,
    input  mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    input  imem_ready, dmem_req, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output forward_a, forward_b,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard / stall / flush controller for the 5-stage RV32I pipeline, with data-memory
// wait watchdog and saturating stall/flush counters. TIMEOUT must be at least 2.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic       clk,
  input logic       rst_n,
  hazard_if.slave   hz
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [15:0] TRIP_W    = 16'(TIMEOUT - 1);

  logic mem_stall;
  logic load_use;
  logic fetch_wait;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [1:0] forward_a, forward_b;

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    mem_stall  = hz.dmem_req & ~hz.dmem_ready;
    load_use   = hz.ex_regwrite & hz.ex_memtoreg & (hz.ex_rd != 5'd0) &
                 ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                  (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    fetch_wait = ~hz.imem_ready;
  end

  // A held MEM stage blocks redirects: ex_pcsrc stays in EX and is acted on once the stall clears.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.ex_pcsrc) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (fetch_wait) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  always_comb begin
    forward_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    forward_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    case (state_q)
      S_IDLE:  if (mem_stall)  state_d = S_WAIT;
      S_WAIT:  if (!mem_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mem_stall) begin
      if (wait_cnt_q != TIMEOUT_W) begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
      if (wait_cnt_q == TRIP_W) begin
        mem_timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 16'd0;
    end

    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (hz.ex_pcsrc && !mem_stall && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hz.stall_f     = stall_f;
  assign hz.stall_d     = stall_d;
  assign hz.stall_e     = stall_e;
  assign hz.stall_m     = stall_m;
  assign hz.flush_d     = flush_d;
  assign hz.flush_e     = flush_e;
  assign hz.flush_w     = flush_w;
  assign hz.forward_a   = forward_a;
  assign hz.forward_b   = forward_b;
  assign hz.mem_timeout = mem_timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4): stimulus queues expectations
// tagged with their cycle; a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int SEL_CTL = 0;
  localparam int SEL_FWD = 1;
  localparam int SEL_TO  = 2;
  localparam int SEL_SC  = 3;
  localparam int SEL_FC  = 4;

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_regwrite, ex_memtoreg, ex_pcsrc;
    logic mem_regwrite, wb_regwrite, imem_ready, dmem_req, dmem_ready;
  } stim_t;

  typedef struct {
    string name;
    int    cyc;
    int    sel;
    int    val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   checks;
  int   passed;
  exp_t sb[$];

  hazard_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic stim_t idle();
    stim_t s;
    s.id_rs1 = 0; s.id_rs2 = 0; s.ex_rs1 = 0; s.ex_rs2 = 0; s.ex_rd = 0;
    s.mem_rd = 0; s.wb_rd = 0;
    s.id_uses_rs1 = 0; s.id_uses_rs2 = 0; s.ex_regwrite = 0; s.ex_memtoreg = 0;
    s.ex_pcsrc = 0; s.mem_regwrite = 0; s.wb_regwrite = 0;
    s.imem_ready = 1; s.dmem_req = 0; s.dmem_ready = 0;
    return s;
  endfunction

  function automatic stim_t loadUse5();
    stim_t s;
    s = idle();
    s.ex_rd = 5; s.ex_regwrite = 1; s.ex_memtoreg = 1;
    s.id_rs1 = 5; s.id_uses_rs1 = 1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bus.id_rs1 = s.id_rs1;           bus.id_rs2 = s.id_rs2;
    bus.id_uses_rs1 = s.id_uses_rs1; bus.id_uses_rs2 = s.id_uses_rs2;
    bus.ex_rs1 = s.ex_rs1;           bus.ex_rs2 = s.ex_rs2;
    bus.ex_rd = s.ex_rd;             bus.ex_regwrite = s.ex_regwrite;
    bus.ex_memtoreg = s.ex_memtoreg; bus.ex_pcsrc = s.ex_pcsrc;
    bus.mem_rd = s.mem_rd;           bus.wb_rd = s.wb_rd;
    bus.mem_regwrite = s.mem_regwrite; bus.wb_regwrite = s.wb_regwrite;
    bus.imem_ready = s.imem_ready;   bus.dmem_req = s.dmem_req;
    bus.dmem_ready = s.dmem_ready;
  endtask

  task automatic checkOutput(input string name, input int sel, input int val);
    exp_t e;
    e.name = name; e.cyc = cycle; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle; counters must read zero before any edge arrives.
  task automatic doReset();
    nextCycle();
    applyStimulus(idle());
    rst_n = 1'b0;
    checkOutput("rst_ctl", SEL_CTL, 0);
    checkOutput("rst_fwd", SEL_FWD, 0);
    checkOutput("rst_timeout", SEL_TO, 0);
    checkOutput("rst_stall_cnt", SEL_SC, 0);
    checkOutput("rst_flush_cnt", SEL_FC, 0);
    nextCycle();
    rst_n = 1'b1;
  endtask

  // Monitor: compare every expectation belonging to the current cycle.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        checks++;
        case (e.sel)
          SEL_CTL: act = 32'({bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                              bus.flush_d, bus.flush_e, bus.flush_w});
          SEL_FWD: act = 32'({bus.forward_a, bus.forward_b});
          SEL_TO:  act = 32'(bus.mem_timeout);
          SEL_SC:  act = 32'(bus.stall_cnt);
          default: act = 32'(bus.flush_cnt);
        endcase
        if (e.cyc != cycle) begin
          $display("[TB] FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cycle);
        end else if (act != 32'(e.val)) begin
          $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.val, cycle);
        end else begin
          passed++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    cycle  = 0;
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    applyStimulus(idle());
    doReset();

    // Load-use through rs1, then non-hazard variants, then load-use through rs2.
    nextCycle(); applyStimulus(loadUse5());
    checkOutput("load_use_rs1", SEL_CTL, 7'b1100010);
    nextCycle(); applyStimulus(idle());
    checkOutput("load_use_idle", SEL_CTL, 0);
    checkOutput("load_use_cnt", SEL_SC, 1);
    nextCycle(); s = loadUse5(); s.ex_rd = 0; s.id_rs1 = 0; applyStimulus(s);
    checkOutput("load_use_x0", SEL_CTL, 0);
    nextCycle(); s = loadUse5(); s.id_uses_rs1 = 0; s.id_rs2 = 5; applyStimulus(s);
    checkOutput("load_use_rs2_unused", SEL_CTL, 0);
    nextCycle(); s.id_uses_rs2 = 1; applyStimulus(s);
    checkOutput("load_use_rs2", SEL_CTL, 7'b1100010);
    nextCycle(); s = loadUse5(); s.ex_memtoreg = 0; applyStimulus(s);
    checkOutput("not_a_load", SEL_CTL, 0);
    checkOutput("load_use_cnt2", SEL_SC, 2);

    // Forwarding: {forward_a, forward_b}.
    nextCycle(); s = idle(); s.ex_rs2 = 7; s.mem_rd = 7; s.wb_rd = 7;
    s.mem_regwrite = 1; s.wb_regwrite = 1; applyStimulus(s);
    checkOutput("fwd_mem_prio", SEL_FWD, 4'b0010);
    nextCycle(); s.mem_rd = 0; applyStimulus(s);
    checkOutput("fwd_wb", SEL_FWD, 4'b0001);
    nextCycle(); s.wb_rd = 0; s.ex_rs2 = 0; applyStimulus(s);
    checkOutput("fwd_x0", SEL_FWD, 4'b0000);
    nextCycle(); s = idle(); s.ex_rs1 = 3; s.ex_rs2 = 3; s.mem_rd = 3; s.wb_rd = 3;
    s.wb_regwrite = 1; applyStimulus(s);
    checkOutput("fwd_mem_we_off", SEL_FWD, 4'b0101);
    nextCycle(); s = idle(); s.ex_rs1 = 9; s.mem_rd = 9; s.mem_regwrite = 1;
    s.ex_rs2 = 4; s.wb_rd = 4; s.wb_regwrite = 1; applyStimulus(s);
    checkOutput("fwd_split", SEL_FWD, 4'b1001);

    // Branch beats load-use and fetch wait.
    nextCycle(); s = loadUse5(); s.ex_pcsrc = 1; s.imem_ready = 0; applyStimulus(s);
    checkOutput("branch_prio", SEL_CTL, 7'b0000110);
    nextCycle(); applyStimulus(idle());
    checkOutput("branch_flush_cnt", SEL_FC, 1);
    checkOutput("branch_stall_cnt", SEL_SC, 2);

    // Fetch wait alone, then fetch wait under load-use.
    nextCycle(); s = idle(); s.imem_ready = 0; applyStimulus(s);
    checkOutput("fetch_wait", SEL_CTL, 7'b1000100);
    nextCycle(); s = loadUse5(); s.imem_ready = 0; applyStimulus(s);
    checkOutput("fetch_wait_load_use", SEL_CTL, 7'b1100010);
    nextCycle(); applyStimulus(idle());
    checkOutput("fetch_stall_cnt", SEL_SC, 4);

    // Memory stall holding a taken branch for 3 cycles.
    doReset();
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); s = idle(); s.dmem_req = 1; s.ex_pcsrc = 1; applyStimulus(s);
      checkOutput("mstall_ctl", SEL_CTL, 7'b1111001);
      checkOutput("mstall_flush_cnt", SEL_FC, 0);
    end
    nextCycle(); s.dmem_ready = 1; applyStimulus(s);
    checkOutput("mstall_release_ctl", SEL_CTL, 7'b0000110);
    checkOutput("mstall_release_sc", SEL_SC, 3);
    checkOutput("mstall_release_fc", SEL_FC, 0);
    nextCycle(); applyStimulus(idle());
    checkOutput("mstall_final_fc", SEL_FC, 1);
    checkOutput("mstall_final_sc", SEL_SC, 3);
    checkOutput("mstall_no_timeout", SEL_TO, 0);

    // Watchdog: 5 stall cycles with TIMEOUT=4, then sticky, then async reset in WAIT.
    doReset();
    for (int i = 1; i <= 5; i++) begin
      nextCycle(); s = idle(); s.dmem_req = 1; applyStimulus(s);
      checkOutput("wdog_timeout", SEL_TO, (i >= 5) ? 1 : 0);
    end
    nextCycle(); s.dmem_ready = 1; applyStimulus(s);
    checkOutput("wdog_sticky_ready", SEL_TO, 1);
    nextCycle(); applyStimulus(idle());
    checkOutput("wdog_sticky_idle", SEL_TO, 1);
    checkOutput("wdog_stall_cnt", SEL_SC, 5);
    nextCycle(); s = idle(); s.dmem_req = 1; applyStimulus(s);
    nextCycle(); applyStimulus(s);
    rst_n = 1'b0;
    checkOutput("async_rst_timeout", SEL_TO, 0);
    checkOutput("async_rst_stall_cnt", SEL_SC, 0);
    nextCycle(); rst_n = 1'b1; applyStimulus(idle());
    checkOutput("async_rst_hold_sc", SEL_SC, 0);

    // Abort in WAIT must clear the wait count: 3 + 3 stall cycles never trip.
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); s = idle(); s.dmem_req = 1; applyStimulus(s);
    end
    nextCycle(); applyStimulus(idle());
    checkOutput("abort_ctl", SEL_CTL, 0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); s = idle(); s.dmem_req = 1; applyStimulus(s);
    end
    nextCycle(); s.dmem_ready = 1; applyStimulus(s);
    checkOutput("abort_no_timeout", SEL_TO, 0);
    nextCycle(); applyStimulus(idle());
    checkOutput("abort_no_timeout2", SEL_TO, 0);
    checkOutput("abort_stall_cnt", SEL_SC, 6);

    // Counter saturation at 4 bits.
    doReset();
    for (int i = 1; i <= 20; i++) begin
      nextCycle(); s = idle(); s.dmem_req = 1; applyStimulus(s);
      if (i == 15) checkOutput("stall_sat_14", SEL_SC, 14);
      if (i == 16) checkOutput("stall_sat_15", SEL_SC, 15);
    end
    nextCycle(); applyStimulus(idle());
    checkOutput("stall_sat_hold", SEL_SC, 15);
    doReset();
    for (int i = 1; i <= 17; i++) begin
      nextCycle(); s = idle(); s.ex_pcsrc = 1; applyStimulus(s);
      if (i == 16) checkOutput("flush_sat_15", SEL_FC, 15);
    end
    nextCycle(); applyStimulus(idle());
    checkOutput("flush_sat_hold", SEL_FC, 15);
    checkOutput("flush_sat_no_stall", SEL_SC, 0);

    nextCycle();
    nextCycle();
    if (sb.size() != 0) begin
      checks += sb.size();
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage RV32I core. It drives the per-stage hold (stall) and clear (flush) inputs of every datapath and control pipeline register: IF/ID, ID/EX, EX/MEM and MEM/WB. It also drives the EX-stage forwarding selects. It owns a data-memory wait FSM with a watchdog, plus saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 64: consecutive data-memory stall cycles before `mem_timeout` is raised. Must be at least 2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  EX destination register.
- ex_regwrite, ex_memtoreg  in  1 each  EX control bits (ex_memtoreg=1 marks a load).
- ex_pcsrc  in  1  branch/jump resolved taken in EX.
- mem_rd, wb_rd  in  5 each  destination registers in MEM and WB.
- mem_regwrite, wb_regwrite  in  1 each  write-enables in MEM and WB.
- imem_ready  in  1  instruction fetch data valid this cycle.
- dmem_req, dmem_ready  in  1 each  MEM-stage access request and completion.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register (1 = hold).
- flush_d, flush_e, flush_w  out  1 each  clear the IF-ID / ID-EX / MEM-WB register to zero.
- forward_a, forward_b  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM result.
- mem_timeout  out  1  sticky watchdog error flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

## Operation
Derived terms (all combinational):
- `mem_stall` = dmem_req & ~dmem_ready.
- `load_use` = ex_regwrite & ex_memtoreg & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- `fetch_wait` = ~imem_ready.

Output rules, highest priority first:
1. `mem_stall`:
   - stall_f, stall_d, stall_e and stall_m are 1.
   - flush_w is 1, so a held MEM instruction is never written back twice.
   - flush_d and flush_e are 0, even if ex_pcsrc=1. EX is held, so ex_pcsrc persists and the redirect is taken after the stall.
2. `ex_pcsrc`:
   - flush_d and flush_e are 1; all stalls are 0.
   - This overrides both `load_use` and `fetch_wait`, because the ID instruction is wrong-path.
3. `load_use`:
   - stall_f and stall_d are 1, and flush_e is 1 (a bubble enters EX).
4. `fetch_wait` alone:
   - stall_f is 1 and flush_d is 1 (a bubble enters ID).
   - If `load_use` is also true, rule 3 applies and flush_d is 0.

Forwarding:
- forward_a is 10 if mem_regwrite & mem_rd != 0 & mem_rd == ex_rs1.
- Otherwise it is 01 if wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1.
- Otherwise it is 00.
- forward_b follows the same rules using ex_rs2. MEM always has priority over WB.

Data-memory FSM (states IDLE and WAIT):
- IDLE goes to WAIT at an edge where `mem_stall` = 1.
- WAIT goes to IDLE at an edge where `mem_stall` = 0. This covers both dmem_ready=1 and dmem_req dropped (abort).
- The 16-bit counter `wait_cnt` increments at each edge with `mem_stall` = 1, saturating at TIMEOUT. It clears at edges with `mem_stall` = 0.
- `mem_timeout` is set at an edge where `mem_stall` = 1 and `wait_cnt` == TIMEOUT-1. It then stays 1 until reset.

Counters:
- stall_cnt increments at each edge where stall_f = 1.
- flush_cnt increments at each edge where ex_pcsrc = 1 and `mem_stall` = 0.
- Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational, with zero latency from their inputs.
- mem_timeout, stall_cnt and flush_cnt are registered and update one edge after the qualifying cycle.
- Reset (asynchronous, immediate on rst_n low):
  - FSM returns to IDLE; wait_cnt is 0; mem_timeout is 0; stall_cnt and flush_cnt are 0.
  - Combinational outputs are 0 for all-zero inputs with imem_ready=1.
  - Reset asserted mid-WAIT clears state and counters immediately.
- `mem_stall` for N consecutive cycles:
  - stall_cnt increases by N.
  - mem_timeout rises after the TIMEOUT-th stall edge: visible from cycle TIMEOUT+1 if N ≥ TIMEOUT; never if N < TIMEOUT.
- A branch blocked by a memory stall is counted once in flush_cnt, at the cycle the stall ends.

## Test plan
- **Load-use:** EX has ex_rd=5, ex_memtoreg=1, ex_regwrite=1; ID has id_rs1=5, id_uses_rs1=1 → stall_f=1, stall_d=1, flush_e=1, flush_d=0. One edge later, stall_cnt=1.
- **Forward priority:** mem_rd=wb_rd=ex_rs2=7 with both write-enables set → forward_b=10. With mem_rd=0 instead → forward_b=01. With x0 in both MEM and WB → forward_b=00.
- **Branch over load-use and fetch wait:** ex_pcsrc=1 while `load_use` is true and imem_ready=0 → flush_d=1, flush_e=1, stall_f=0, stall_d=0. flush_cnt increments by 1.
- **Memory stall with branch:** dmem_req=1, dmem_ready=0 for 3 cycles with ex_pcsrc=1 → during those cycles stall_f/d/e/m=1, flush_w=1, flush_d=0, flush_e=0. In cycle 4, dmem_ready=1 → flush_d=1, flush_e=1. Final flush_cnt=1, stall_cnt=3.
- **Watchdog:** TIMEOUT=4 with `mem_stall` held 5 cycles → mem_timeout=0 through cycle 4 and 1 from cycle 5. It remains 1 after dmem_ready. Pulsing rst_n low clears it asynchronously.
- **Abort and saturation:** dropping dmem_req in WAIT returns the FSM to IDLE with wait_cnt=0. With CNT_W=4 and 20 stall cycles, stall_cnt=15.
